rs232_receive_os: RTL and testbench

- Oversampling RS-232/UART receiver. It recovers 8N1 frames from an asynchronous serial line and presents each byte with a one-cycle valid strobe.
- It is the receive direction paired with rs232_transmit. It replaces the simple centre-sample receiver where noisy lines or baud mismatch demand start-bit qualification, majority voting and framing-error reporting.

---
 rtl/rs232_pkg.sv | 24 ++
 rtl/rs232_receive_os_if.sv | 26 ++
 rtl/rs232_baud_tick.sv | 34 +++
 rtl/rs232_receive_os.sv | 135 +++++++++++++
 tb/tb_rs232_receive_os.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 pair: receiver state encoding, frame width
// and the baud divider so both directions derive the same bit timing.
package rs232_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_e;

  // System clocks per oversampling tick, truncated.
  function automatic int calc_div(input int clk_freq, input int baud, input int os_rate);
    return clk_freq / (baud * os_rate);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rs232_receive_os_if.sv
// Receiver-side signal bundle: serial line in, recovered byte and status out,
// plus the FSM state for observation.
interface rs232_receive_os_if;
  import rs232_pkg::*;

  // valid/frame_err are single-cycle strobes with no backpressure: the byte on
  // data_receive is new exactly in the cycle valid is high and holds until the
  // next valid; valid and frame_err never assert together.
  logic                 serial_in;
  logic [DATA_BITS-1:0] data_receive;
  logic                 valid;
  logic                 frame_err;
  logic                 busy;
  rx_state_e            state;

  modport master (
    input  serial_in,
    output data_receive, valid, frame_err, busy, state
  );

  modport slave (
    output serial_in,
    input  data_receive, valid, frame_err, busy, state
  );

endinterface

// File: rtl/rs232_baud_tick.sv
// Oversampling tick generator: one-cycle pulse every DIV clocks, restartable so
// the tick phase can be locked to a detected line edge.
module rs232_baud_tick
  import rs232_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int OS_RATE  = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  output logic tick_o
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OS_RATE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == LAST) && !clear_i;

endmodule

// File: rtl/rs232_receive_os.sv
// Oversampling 8N1 receiver: start-bit qualification, 2-of-3 mid-bit voting,
// framing-error reporting and break hold-off.
module rs232_receive_os
  import rs232_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int OS_RATE  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  rs232_receive_os_if.master rx_if
);

  localparam int SW = $clog2(OS_RATE);
  localparam logic [SW-1:0] S_LAST = SW'(OS_RATE - 1);
  localparam logic [SW-1:0] S_V0   = SW'(OS_RATE / 2 - 1);
  localparam logic [SW-1:0] S_V1   = SW'(OS_RATE / 2);
  localparam logic [SW-1:0] S_V2   = SW'(OS_RATE / 2 + 1);
  localparam logic [2:0]    B_LAST = 3'(DATA_BITS - 1);

  rx_state_e            state_q;
  logic                 sync1_q, rx_s_q;
  logic [1:0]           fill_q;
  logic                 idle_seen_q;
  logic [SW-1:0]        scnt_q;
  logic [2:0]           bcnt_q;
  logic [1:0]           smp_q;
  logic                 vote_q;
  logic [DATA_BITS-1:0] shreg_q, data_q;
  logic                 valid_q, ferr_q;

  logic          tick, tick_clr, vote_d, sampling;
  logic [SW-1:0] scnt_d;

  // In BREAK the tick counter only runs while the line is high, so a tick
  // there means one full tick period of idle line.
  assign tick_clr = (state_q == IDLE) || ((state_q == BREAK) && !rx_s_q);
  assign vote_d   = maj3(smp_q[0], smp_q[1], rx_s_q);
  assign scnt_d   = (scnt_q == S_LAST) ? '0 : scnt_q + 1'b1;
  assign sampling = tick && (state_q inside {START, DATA, STOP});

  rs232_baud_tick #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD),
    .OS_RATE (OS_RATE)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear_i(tick_clr),
    .tick_o (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      fill_q      <= '0;
      idle_seen_q <= 1'b0;
      state_q     <= IDLE;
      scnt_q      <= '0;
      bcnt_q      <= '0;
      smp_q       <= '0;
      vote_q      <= 1'b0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      sync1_q <= rx_if.serial_in;
      rx_s_q  <= sync1_q;
      // rx_s only reflects the real line once the reset values have flushed.
      fill_q  <= {fill_q[0], 1'b1};
      if (fill_q[1] && rx_s_q) idle_seen_q <= 1'b1;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;

      if (sampling) begin
        scnt_q <= scnt_d;
        if (scnt_q == S_V0) smp_q[0] <= rx_s_q;
        if (scnt_q == S_V1) smp_q[1] <= rx_s_q;
        if (scnt_q == S_V2) vote_q   <= vote_d;
      end

      case (state_q)
        IDLE: begin
          if (idle_seen_q && !rx_s_q) begin
            state_q <= START;
            scnt_q  <= '0;
            bcnt_q  <= '0;
          end
        end
        START: begin
          if (tick && (scnt_q == S_V2) && vote_d) begin
            state_q <= IDLE;
          end else if (tick && (scnt_q == S_LAST)) begin
            state_q <= DATA;
            bcnt_q  <= '0;
          end
        end
        DATA: begin
          if (tick && (scnt_q == S_LAST)) begin
            shreg_q <= {vote_q, shreg_q[DATA_BITS-1:1]};
            bcnt_q  <= bcnt_q + 3'd1;
            if (bcnt_q == B_LAST) state_q <= STOP;
          end
        end
        STOP: begin
          // Leave mid-stop-bit so the next start edge is never missed.
          if (tick && (scnt_q == S_V2)) begin
            if (vote_d) begin
              data_q  <= shreg_q;
              valid_q <= 1'b1;
              state_q <= IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= BREAK;
            end
          end
        end
        BREAK: begin
          if (tick) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_if.data_receive = data_q;
  assign rx_if.valid        = valid_q;
  assign rx_if.frame_err    = ferr_q;
  assign rx_if.busy         = (state_q != IDLE);
  assign rx_if.state        = state_q;

endmodule

// File: tb/tb_rs232_receive_os.sv
// Directed bench for rs232_receive_os: table of single frames plus hand-written
// back-to-back, glitch, framing/break and mid-frame reset sequences.
module tb_rs232_receive_os;
  import rs232_pkg::*;

  localparam int CLK_FREQ = 50000000;
  localparam int BAUD     = 115200;
  localparam int OS_RATE  = 16;
  localparam int BIT_P    = 432;  // 16 ticks x 27 clocks per nominal bit

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  rs232_receive_os_if rx_if ();

  rs232_receive_os #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD    (BAUD),
    .OS_RATE (OS_RATE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rx_if(rx_if)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  logic [7:0] exp_q[$];
  logic prev_valid = 1'b0;
  logic prev_ferr  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n) begin
      if (rx_if.valid) begin
        valid_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: data %0h, no byte expected", rx_if.data_receive);
        end else begin
          e = exp_q.pop_front();
          if (rx_if.data_receive !== e) begin
            errors++;
            $display("FAIL rx_data: got %0h, expected %0h", rx_if.data_receive, e);
          end
        end
        check("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
        check("valid_ferr_exclusive", {31'd0, rx_if.frame_err}, 32'd0);
      end
      if (rx_if.frame_err) begin
        ferr_cnt++;
        check("ferr_one_cycle", {31'd0, prev_ferr}, 32'd0);
      end
      prev_valid = rx_if.valid;
      prev_ferr  = rx_if.frame_err;
    end else begin
      prev_valid = 1'b0;
      prev_ferr  = 1'b0;
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input logic v, input int n);
    rx_if.serial_in = v;
    repeat (n) @(negedge clk);
  endtask

  // spike_pos: bit position (0=start, 1..8 data, 9=stop) to receive a short
  // inverted pulse around its second vote sample; -1 for none.
  task automatic send_frame(input logic [7:0] d, input int period, input logic stop_v,
                            input int spike_pos);
    logic b;
    for (int pos = 0; pos < 10; pos++) begin
      b = (pos == 0) ? 1'b0 : (pos == 9) ? stop_v : d[pos-1];
      if (pos == spike_pos) begin
        drive(b, 236);
        drive(~b, 14);
        drive(b, period - 250);
      end else begin
        drive(b, period);
      end
    end
  endtask

  typedef struct {
    logic [7:0] data;
    int         period;
    int         spike_pos;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[4];
  int v0, f0;

  initial begin
    vecs[0] = '{data: 8'hA5, period: 432, spike_pos: -1, exp_data: 8'hA5};
    vecs[1] = '{data: 8'hC3, period: 419, spike_pos: -1, exp_data: 8'hC3};  // +3% baud
    vecs[2] = '{data: 8'hC3, period: 445, spike_pos: -1, exp_data: 8'hC3};  // -3% baud
    vecs[3] = '{data: 8'hC3, period: 432, spike_pos: 5,  exp_data: 8'hC3};  // spike in data bit 4

    rx_if.serial_in = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_data", {24'd0, rx_if.data_receive}, 32'h00);
    check("reset_valid", {31'd0, rx_if.valid}, 32'd0);
    check("reset_ferr", {31'd0, rx_if.frame_err}, 32'd0);
    check("reset_busy", {31'd0, rx_if.busy}, 32'd0);
    check("reset_state", 32'(rx_if.state), 32'(IDLE));
    rst_n = 1'b1;
    drive(1'b1, 20);

    // ---------------- table-driven single frames ----------------
    foreach (vecs[i]) begin
      v0 = valid_cnt;
      f0 = ferr_cnt;
      exp_q.push_back(vecs[i].exp_data);
      send_frame(vecs[i].data, vecs[i].period, 1'b1, vecs[i].spike_pos);
      drive(1'b1, 2 * BIT_P);
      check($sformatf("vec%0d_valid_count", i), 32'(valid_cnt - v0), 32'd1);
      check($sformatf("vec%0d_ferr_count", i), 32'(ferr_cnt - f0), 32'd0);
      check($sformatf("vec%0d_data", i), {24'd0, rx_if.data_receive}, {24'd0, vecs[i].exp_data});
      check($sformatf("vec%0d_busy_idle", i), {31'd0, rx_if.busy}, 32'd0);
    end

    // ---------------- back-to-back frames ----------------
    v0 = valid_cnt;
    f0 = ferr_cnt;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h3C);
    send_frame(8'h00, BIT_P, 1'b1, -1);
    send_frame(8'hFF, BIT_P, 1'b1, -1);
    send_frame(8'h3C, BIT_P, 1'b1, -1);
    drive(1'b1, 2 * BIT_P);
    check("b2b_valid_count", 32'(valid_cnt - v0), 32'd3);
    check("b2b_ferr_count", 32'(ferr_cnt - f0), 32'd0);
    check("b2b_last_data", {24'd0, rx_if.data_receive}, 32'h3C);

    // ---------------- one-tick glitch on idle line ----------------
    v0 = valid_cnt;
    f0 = ferr_cnt;
    drive(1'b0, 27);
    drive(1'b1, 50);
    check("glitch_busy_seen", {31'd0, rx_if.busy}, 32'd1);
    drive(1'b1, BIT_P);
    check("glitch_busy_cleared", {31'd0, rx_if.busy}, 32'd0);
    check("glitch_valid_count", 32'(valid_cnt - v0), 32'd0);
    check("glitch_ferr_count", 32'(ferr_cnt - f0), 32'd0);

    // ---------------- framing error and held-low break ----------------
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h55, BIT_P, 1'b0, -1);
    drive(1'b0, 30 * BIT_P);
    check("break_ferr_count", 32'(ferr_cnt - f0), 32'd1);
    check("break_valid_count", 32'(valid_cnt - v0), 32'd0);
    check("break_data_kept", {24'd0, rx_if.data_receive}, 32'h3C);
    check("break_busy_held", {31'd0, rx_if.busy}, 32'd1);
    check("break_state", 32'(rx_if.state), 32'(BREAK));
    drive(1'b1, 2 * BIT_P);
    check("break_exit_busy", {31'd0, rx_if.busy}, 32'd0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, BIT_P, 1'b1, -1);
    drive(1'b1, 2 * BIT_P);
    check("after_break_valid_count", 32'(valid_cnt - v0), 32'd1);
    check("after_break_data", {24'd0, rx_if.data_receive}, 32'h81);

    // ---------------- reset in the middle of bit 3 of 0x96 ----------------
    v0 = valid_cnt;
    f0 = ferr_cnt;
    drive(1'b0, BIT_P);
    drive(1'b0, BIT_P);  // bit0 of 0x96
    drive(1'b1, BIT_P);  // bit1
    drive(1'b1, BIT_P);  // bit2
    drive(1'b0, BIT_P / 2);  // first half of bit3
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_data", {24'd0, rx_if.data_receive}, 32'h00);
    check("midrst_valid", {31'd0, rx_if.valid}, 32'd0);
    check("midrst_ferr", {31'd0, rx_if.frame_err}, 32'd0);
    check("midrst_busy", {31'd0, rx_if.busy}, 32'd0);
    check("midrst_state", 32'(rx_if.state), 32'(IDLE));
    rst_n = 1'b1;
    drive(1'b0, BIT_P / 2);
    check("midrst_low_no_start", {31'd0, rx_if.busy}, 32'd0);
    drive(1'b1, 2 * BIT_P);
    check("midrst_no_pulses", 32'(valid_cnt - v0 + ferr_cnt - f0), 32'd0);
    exp_q.push_back(8'h69);
    send_frame(8'h69, BIT_P, 1'b1, -1);
    drive(1'b1, 2 * BIT_P);
    check("midrst_next_valid_count", 32'(valid_cnt - v0), 32'd1);
    check("midrst_next_data", {24'd0, rx_if.data_receive}, 32'h69);

    check("expected_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
